seg_load_ctrl: RTL and testbench
================================

SEG_LOAD_CTRL -- requirements
Module: seg_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of BCD digits held and counted.
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port btn  input  NUM_DIGITS  per-digit load buttons, already synchronized, level.
REQ-005 SHALL have port start_btn  input  1  run/stop toggle button, already synchronized, level.
REQ-006 SHALL have port sw  input  4  load value for the granted digit.
REQ-007 SHALL have port tick  input  1  single-cycle count enable.
REQ-008 SHALL have port digits  output  4*NUM_DIGITS  BCD digit bank; digit i is bits [4i+3:4i].
REQ-009 SHALL have port load_ack  output  NUM_DIGITS  one-hot pulse marking the digit written this cycle.
REQ-010 SHALL have port running  output  1  high while in state RUN.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on counter rollover.

Function
REQ-012 SHALL rising-edge-detect each btn bit and start_btn: edge flag = sampled-now AND NOT sampled-previous, two flops per input.
REQ-013 SHALL set pending[i] on the clock edge after btn[i]'s edge flag is high; repeated edges while pending[i] is set merge.
REQ-014 SHALL implement three states: IDLE, LOAD and RUN.
REQ-015 IDLE: start edge -> RUN (priority); else pending != 0 -> LOAD; else stay.
REQ-016 LOAD: each cycle grant exactly one pending digit, round-robin starting at the index after the last grant (index 0 after reset).
REQ-017 Grant: digit[i] <= min(sw, 9); pending[i] cleared; load_ack[i] high for that cycle only.
REQ-018 A new edge on btn[i] in its own grant cycle SHALL leave pending[i] set.
REQ-019 LOAD: start edge -> RUN after the current grant; else if no pending remains after the grant -> IDLE.
REQ-020 RUN: tick increments the digit bank as a NUM_DIGITS-digit BCD counter; digit 0 is least significant, with ripple carry 9->0.
REQ-021 In RUN, all-nines plus tick SHALL give all-zeros and pulse wrap for one cycle.
REQ-022 RUN: start edge -> IDLE; a tick in the same cycle SHALL still be applied.
REQ-023 In RUN, load edges SHALL still set pending without modifying digits; they are served after return to IDLE.
REQ-024 tick outside RUN SHALL be ignored.
REQ-025 Latency: btn sampled high at edge k (low at k-1) -> pending at k+1 -> LOAD at k+2 -> earliest write at k+3.

Reset
REQ-026 Reset SHALL set: state IDLE; digits, pending, load_ack, wrap and running to 0; round-robin pointer to 0; all edge-detector flops to 0.
REQ-027 Reset asserted mid-LOAD or mid-RUN SHALL abort immediately and discard pending requests.
REQ-028 An input held high through reset release SHALL register one edge on the first post-reset sample.

Structure
REQ-029 Package seg_ctrl_pkg SHALL hold the state enum (IDLE, LOAD, RUN), BCD_MAX=9 and the 4-bit BCD digit type.
REQ-030 Sub-module edge_det (clk, reset, din, rise) SHALL be instantiated NUM_DIGITS+1 times.
REQ-031 Arbiter, pending register, FSM and BCD counter SHALL reside in seg_load_ctrl.

Verification
REQ-032 Single load: sw=5, pulse btn[2] -> digits=16'h0500 and load_ack=4'b0100 for one cycle, 3 cycles after the sample edge.
REQ-033 Simultaneous btn=4'b1111 with sw=7 -> four consecutive grants in order 0,1,2,3; digits=16'h7777; then IDLE.
REQ-034 Saturation: sw=4'hC, pulse btn[0] -> digit 0 = 9.
REQ-035 Count: digits=16'h0999, RUN, one tick -> 16'h1000; digits=16'h9999, one tick -> 16'h0000 with a one-cycle wrap pulse.
REQ-036 Load during RUN: pulse btn[1] with sw=3 -> digits unchanged; after start edge returns IDLE -> digit 1 = 3.
REQ-037 Reset mid-LOAD with three pending -> all outputs 0 and no grants after release.

Source files
------------

// File: rtl/seg_ctrl_pkg.sv
// Shared types and constants for the segment load controller.
// Holds the controller state encoding and the BCD digit helpers.
package seg_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_e;

   typedef logic [3:0] digit_t;

   localparam digit_t BCD_MAX = 4'd9;

   // Switch values above 9 clamp to 9 so the bank always holds valid BCD.
   function automatic digit_t sat_bcd(input logic [3:0] v);
      return (v > BCD_MAX) ? BCD_MAX : v;
   endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for an already-synchronized level input.
// rise is high for the cycle after the first high sample of din.
module edge_det (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic sample_q;
   logic prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_q <= 1'b0;
         prev_q   <= 1'b0;
      end else begin
         sample_q <= din;
         prev_q   <= sample_q;
      end
   end

   assign rise = sample_q & ~prev_q;

endmodule

// File: rtl/seg_load_ctrl.sv
// Digit bank controller: buttons queue per-digit loads served round-robin,
// start toggles a BCD up-counter driven by tick.
module seg_load_ctrl
   import seg_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_DIGITS-1:0]   btn,
   input  logic                    start_btn,
   input  logic [3:0]              sw,
   input  logic                    tick,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   load_ack,
   output logic                    running,
   output logic                    wrap
);

   localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [NUM_DIGITS-1:0]   btn_rise;
   logic                    start_rise;

   state_e                  state_q, state_d;
   logic [NUM_DIGITS-1:0]   pending_q, pending_d;
   logic [PW-1:0]           ptr_q, ptr_d;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   load_ack_q, load_ack_d;
   logic                    wrap_q, wrap_d;

   logic                    grant_found;
   logic [PW-1:0]           grant_idx;
   logic                    grant_valid;
   logic [4*NUM_DIGITS-1:0] digits_inc;
   logic                    inc_carry;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_btn_edge
      edge_det u_btn_edge (
         .clk   (clk),
         .reset (reset),
         .din   (btn[g]),
         .rise  (btn_rise[g])
      );
   end

   edge_det u_start_edge (
      .clk   (clk),
      .reset (reset),
      .din   (start_btn),
      .rise  (start_rise)
   );

   // Round-robin search: first pending digit at or after ptr_q, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         int idx;
         idx = int'(ptr_q) + k;
         if (idx >= NUM_DIGITS) idx = idx - NUM_DIGITS;
         if (!grant_found && pending_q[idx]) begin
            grant_found = 1'b1;
            grant_idx   = PW'(idx);
         end
      end
   end

   assign grant_valid = (state_q == LOAD) && grant_found;

   // Ripple-carry BCD increment; inc_carry out of the top digit means rollover.
   always_comb begin
      digits_inc = digits_q;
      inc_carry  = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (inc_carry) begin
            if (digits_q[4*i +: 4] == BCD_MAX) begin
               digits_inc[4*i +: 4] = 4'd0;
            end else begin
               digits_inc[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
               inc_carry            = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      digits_d   = digits_q;
      load_ack_d = '0;
      wrap_d     = 1'b0;
      pending_d  = pending_q;

      if (grant_valid) begin
         pending_d[grant_idx]          = 1'b0;
         load_ack_d[grant_idx]         = 1'b1;
         digits_d[4*int'(grant_idx) +: 4] = sat_bcd(sw);
         ptr_d = (grant_idx == PW'(NUM_DIGITS - 1)) ? '0 : grant_idx + PW'(1);
      end
      // New edges OR in after the clear, so a re-press during its own grant survives.
      pending_d = pending_d | btn_rise;

      unique case (state_q)
         IDLE: begin
            if (start_rise)             state_d = RUN;
            else if (pending_q != '0)   state_d = LOAD;
         end
         LOAD: begin
            if (start_rise)             state_d = RUN;
            else if (pending_d == '0)   state_d = IDLE;
         end
         RUN: begin
            if (tick) begin
               digits_d = digits_inc;
               wrap_d   = inc_carry;
            end
            if (start_rise)             state_d = IDLE;
         end
         default:                       state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         ptr_q      <= '0;
         digits_q   <= '0;
         load_ack_q <= '0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         ptr_q      <= ptr_d;
         digits_q   <= digits_d;
         load_ack_q <= load_ack_d;
         wrap_q     <= wrap_d;
      end
   end

   assign digits   = digits_q;
   assign load_ack = load_ack_q;
   assign wrap     = wrap_q;
   assign running  = (state_q == RUN);

endmodule

// File: tb/tb_seg_load_ctrl.sv
// Self-checking bench for seg_load_ctrl: a grant scoreboard fed by the
// stimulus, a vector table of single loads, and hand-written corner sequences.
module tb_seg_load_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  btn = '0;
   logic        start_btn = 1'b0;
   logic [3:0]  sw = '0;
   logic        tick = 1'b0;
   logic [15:0] digits;
   logic [3:0]  load_ack;
   logic        running;
   logic        wrap;

   int checks = 0;
   int failures = 0;
   int grants_seen = 0;

   // Each entry is {expected one-hot load_ack, expected digit value}.
   logic [7:0] exp_q[$];

   typedef struct {
      logic [3:0]  btn;
      logic [3:0]  sw;
      logic [3:0]  exp_val;
      logic [15:0] exp_digits;
   } vec_t;

   vec_t tbl[5];

   seg_load_ctrl #(.NUM_DIGITS(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn),
      .start_btn (start_btn),
      .sw        (sw),
      .tick      (tick),
      .digits    (digits),
      .load_ack  (load_ack),
      .running   (running),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Grant monitor: every load_ack pulse must match the oldest expected grant.
   always @(negedge clk) begin
      if (!reset && load_ack != '0) begin
         logic [3:0] act_val;
         logic [7:0] e;
         act_val = '0;
         for (int i = 0; i < 4; i++)
            if (load_ack[i]) act_val = digits[4*i +: 4];
         grants_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_grant: got ack %b val %0h expected no grant", load_ack, act_val);
         end else begin
            e = exp_q.pop_front();
            check("grant", {24'd0, load_ack, act_val}, {24'd0, e});
         end
      end
   end

   task automatic pulse_btn(input logic [3:0] mask);
      btn = mask;
      @(negedge clk);
      btn = '0;
   endtask

   task automatic pulse_start();
      start_btn = 1'b1;
      @(negedge clk);
      start_btn = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(name, exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      btn = '0;
      start_btn = 1'b0;
      tick = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int n;
      int gs;

      tbl[0] = '{btn: 4'b0001, sw: 4'hC, exp_val: 4'h9, exp_digits: 16'h7779};
      tbl[1] = '{btn: 4'b0010, sw: 4'h3, exp_val: 4'h3, exp_digits: 16'h7739};
      tbl[2] = '{btn: 4'b1000, sw: 4'h0, exp_val: 4'h0, exp_digits: 16'h0739};
      tbl[3] = '{btn: 4'b0100, sw: 4'hF, exp_val: 4'h9, exp_digits: 16'h0939};
      tbl[4] = '{btn: 4'b0010, sw: 4'h9, exp_val: 4'h9, exp_digits: 16'h0999};

      // Reset state.
      @(negedge clk);
      check("rst_digits", digits, 16'h0000);
      check("rst_ack", load_ack, 4'b0000);
      check("rst_running", running, 1'b0);
      check("rst_wrap", wrap, 1'b0);
      do_reset();

      // Single load and its latency from the sample edge.
      sw = 4'd5;
      btn = 4'b0100;
      exp_q.push_back({4'b0100, 4'd5});
      @(negedge clk);
      btn = '0;
      check("lat_k1_ack", load_ack, 4'b0000);
      @(negedge clk);
      check("lat_k2_ack", load_ack, 4'b0000);
      @(negedge clk);
      check("lat_k3_ack", load_ack, 4'b0000);
      @(negedge clk);
      check("lat_ack", load_ack, 4'b0100);
      check("lat_digits", digits, 16'h0500);
      @(negedge clk);
      check("lat_ack_drop", load_ack, 4'b0000);

      // All four buttons at once from a fresh pointer: grants 0,1,2,3 back to back.
      do_reset();
      sw = 4'd7;
      for (int i = 0; i < 4; i++) exp_q.push_back({4'(1 << i), 4'd7});
      pulse_btn(4'b1111);
      n = 0;
      while (load_ack == '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("all_first", load_ack, 4'b0001);
      @(negedge clk);
      check("all_second", load_ack, 4'b0010);
      @(negedge clk);
      check("all_third", load_ack, 4'b0100);
      @(negedge clk);
      check("all_fourth", load_ack, 4'b1000);
      @(negedge clk);
      check("all_done", load_ack, 4'b0000);
      check("all_digits", digits, 16'h7777);
      drain("all_drain");

      // Vector table of single loads including saturation.
      for (int v = 0; v < 5; v++) begin
         sw = tbl[v].sw;
         exp_q.push_back({tbl[v].btn, tbl[v].exp_val});
         pulse_btn(tbl[v].btn);
         drain("tbl_drain");
         check($sformatf("tbl_digits_%0d", v), digits, tbl[v].exp_digits);
      end

      // Round robin from pointer 2: request {3,1,0} is served 3,0,1.
      sw = 4'd1;
      exp_q.push_back({4'b1000, 4'd1});
      exp_q.push_back({4'b0001, 4'd1});
      exp_q.push_back({4'b0010, 4'd1});
      pulse_btn(4'b1011);
      drain("rr_drain");
      check("rr_digits", digits, 16'h1911);

      // Rebuild 0999 for the counter test (pointer is 2 again, so 0 then 1).
      sw = 4'd9;
      exp_q.push_back({4'b0001, 4'd9});
      exp_q.push_back({4'b0010, 4'd9});
      pulse_btn(4'b0011);
      drain("set_a_drain");
      sw = 4'd0;
      exp_q.push_back({4'b1000, 4'd0});
      pulse_btn(4'b1000);
      drain("set_b_drain");
      check("set_digits", digits, 16'h0999);

      // Counting with carry ripple.
      pulse_start();
      check("run_enter", running, 1'b1);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      check("cnt_carry", digits, 16'h1000);
      check("cnt_nowrap", wrap, 1'b0);

      // Stop edge with a tick in the same cycle: tick still counts.
      start_btn = 1'b1;
      @(negedge clk);
      start_btn = 1'b0;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      check("stop_running", running, 1'b0);
      check("stop_tick", digits, 16'h1001);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      check("idle_tick", digits, 16'h1001);

      // All nines rolls over with a one-cycle wrap.
      sw = 4'd9;
      for (int i = 0; i < 4; i++) exp_q.push_back({4'(1 << i), 4'd9});
      pulse_btn(4'b1111);
      drain("nines_drain");
      check("nines_digits", digits, 16'h9999);
      pulse_start();
      check("run2_enter", running, 1'b1);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      check("roll_digits", digits, 16'h0000);
      check("roll_wrap", wrap, 1'b1);
      @(negedge clk);
      check("roll_wrap_drop", wrap, 1'b0);

      // Load request during RUN waits until the controller is back in IDLE.
      sw = 4'd3;
      exp_q.push_back({4'b0010, 4'd3});
      pulse_btn(4'b0010);
      repeat (6) @(negedge clk);
      check("run_load_digits", digits, 16'h0000);
      check("run_load_held", exp_q.size(), 1);
      check("run_load_running", running, 1'b1);
      pulse_start();
      check("run_exit", running, 1'b0);
      drain("run_load_drain");
      check("run_load_served", digits, 16'h0030);

      // Reset in LOAD with three pending: everything clears, nothing is granted after.
      sw = 4'd2;
      btn = 4'b0111;
      @(negedge clk);
      btn = '0;
      repeat (2) @(negedge clk);
      check("mid_pre_ack", load_ack, 4'b0000);
      check("mid_pre_digits", digits, 16'h0030);
      gs = grants_seen;
      reset = 1'b1;
      #1;
      check("mid_digits", digits, 16'h0000);
      check("mid_ack", load_ack, 4'b0000);
      check("mid_running", running, 1'b0);
      check("mid_wrap", wrap, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check("mid_after_digits", digits, 16'h0000);
      check("mid_after_grants", grants_seen, gs);

      // Button held through reset release counts as one edge.
      reset = 1'b1;
      btn = 4'b0001;
      sw = 4'd6;
      @(negedge clk);
      reset = 1'b0;
      exp_q.push_back({4'b0001, 4'd6});
      repeat (8) @(negedge clk);
      btn = '0;
      drain("held_drain");
      repeat (5) @(negedge clk);
      check("held_digits", digits, 16'h0006);
      check("held_single", grants_seen, gs + 1);

      check("final_queue", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
